// File: rtl/hack_ctrl_pkg.sv
// Shared state encoding and Hack instruction bit positions for the fetch/execute controller.
package hack_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM,
    UPDATE,
    HALT
  } state_t;

  localparam int unsigned C_BIT      = 15;
  localparam int unsigned A_BIT      = 12;
  localparam int unsigned DEST_M_BIT = 3;
  localparam int unsigned J_LT       = 2;
  localparam int unsigned J_EQ       = 1;
  localparam int unsigned J_GT       = 0;

endpackage

// File: rtl/hack_jump_eval.sv
// Jump condition for a Hack C-instruction from its jump field and the latched ALU flags.
module hack_jump_eval
  import hack_ctrl_pkg::*;
(
  input  logic       c_instr,
  input  logic [2:0] jbits,
  input  logic       zr,
  input  logic       ng,
  output logic       jump
);

  always_comb begin
    jump = c_instr & ((jbits[J_LT] & ng) |
                      (jbits[J_EQ] & zr) |
                      (jbits[J_GT] & ~ng & ~zr));
  end

endmodule

// File: rtl/hack_pc_sequencer.sv
// Multi-cycle fetch/execute controller for the Hack CPU: ROM fetch, M-operand access,
// jump evaluation and PC strobes, with a bus timeout and self-jump halt detection.
module hack_pc_sequencer
  import hack_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned HALT_DETECT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_en,
  output logic             rom_req,
  input  logic             rom_ack,
  input  logic [WIDTH-1:0] rom_data,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] pc_value,
  input  logic [WIDTH-1:0] a_value,
  input  logic             zr,
  input  logic             ng,
  output logic [WIDTH-1:0] instr,
  output logic             exec_en,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             halted,
  output logic             bus_err
);

  state_t     state, state_next;
  logic [7:0] tmo_cnt;
  logic       zr_q, ng_q;
  logic       jump;
  logic       needs_mem;
  logic       waiting;
  logic       tmo_hit;

  hack_jump_eval u_jump (
    .c_instr (instr[C_BIT]),
    .jbits   (instr[J_LT:J_GT]),
    .zr      (zr_q),
    .ng      (ng_q),
    .jump    (jump)
  );

  assign needs_mem = instr[C_BIT] & (instr[A_BIT] | instr[DEST_M_BIT]);
  // An ack arriving on the last allowed cycle still completes the access.
  assign waiting   = ((state == FETCH) & ~rom_ack) | ((state == MEM) & ~mem_ack);
  assign tmo_hit   = waiting & (tmo_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run_en) state_next = FETCH;
      FETCH:   if (rom_ack) state_next = EXEC;
               else if (tmo_hit) state_next = HALT;
      EXEC:    state_next = needs_mem ? MEM : UPDATE;
      MEM:     if (mem_ack) state_next = UPDATE;
               else if (tmo_hit) state_next = HALT;
      UPDATE:  if ((HALT_DETECT != 0) && jump && (a_value == pc_value)) state_next = HALT;
               else if (run_en) state_next = FETCH;
               else state_next = IDLE;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rom_req = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    exec_en = 1'b0;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    halted  = 1'b0;
    case (state)
      FETCH:  rom_req = 1'b1;
      EXEC:   exec_en = 1'b1;
      MEM: begin
        mem_req = 1'b1;
        mem_we  = instr[DEST_M_BIT];
      end
      UPDATE: begin
        pc_load = jump;
        pc_inc  = ~jump;
      end
      HALT:   halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr   <= '0;
      tmo_cnt <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if ((state == FETCH) && rom_ack) instr <= rom_data;
      if (state == EXEC) begin
        zr_q <= zr;
        ng_q <= ng;
      end
      if ((state_next != state) && ((state_next == FETCH) || (state_next == MEM)))
        tmo_cnt <= '0;
      else if (waiting)
        tmo_cnt <= tmo_cnt + 8'd1;
      if (tmo_hit) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hack_pc_sequencer.sv
// Self-checking bench for hack_pc_sequencer: instruction table with a strobe scoreboard,
// plus directed sequences for halt, timeouts, reset and run_en corner cases.
module tb_hack_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_en = 1'b0;
  logic        rom_req;
  logic        rom_ack = 1'b0;
  logic [15:0] rom_data = '0;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack = 1'b0;
  logic [15:0] pc_value = '0;
  logic [15:0] a_value = '0;
  logic        zr = 1'b0;
  logic        ng = 1'b0;
  logic [15:0] instr;
  logic        exec_en;
  logic        pc_load;
  logic        pc_inc;
  logic        halted;
  logic        bus_err;

  hack_pc_sequencer #(.WIDTH(16), .TIMEOUT(4), .HALT_DETECT(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .run_en   (run_en),
    .rom_req  (rom_req),
    .rom_ack  (rom_ack),
    .rom_data (rom_data),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_ack  (mem_ack),
    .pc_value (pc_value),
    .a_value  (a_value),
    .zr       (zr),
    .ng       (ng),
    .instr    (instr),
    .exec_en  (exec_en),
    .pc_load  (pc_load),
    .pc_inc   (pc_inc),
    .halted   (halted),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic        zr;
    logic        ng;
    logic        aeq;
    int unsigned mwait;
    logic        pl;
    logic        pi;
    int unsigned cyc;
    int unsigned mc;
    logic        we;
  } vec_t;

  typedef struct {
    logic        pl;
    logic        pi;
    int unsigned cyc;
    int unsigned mc;
    logic        we;
  } exp_t;

  vec_t        tbl[14];
  vec_t        cur;
  exp_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned obs_cyc, obs_mc, obs_exec, n_strobes, seen_rom;
  logic        obs_we;
  logic        ack_rom = 1'b1;
  logic        found;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    obs_cyc  = 0;
    obs_mc   = 0;
    obs_exec = 0;
    obs_we   = 1'b0;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.pl  = v.pl;
    e.pi  = v.pi;
    e.cyc = v.cyc;
    e.mc  = v.mc;
    e.we  = v.we;
    q.push_back(e);
  endtask

  // One clock: observe outputs at the falling edge, score strobes, then answer handshakes.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (rom_req | exec_en | mem_req | pc_load | pc_inc) obs_cyc++;
    if (exec_en) obs_exec = obs_cyc;
    if (mem_req) begin
      obs_mc++;
      obs_we = obs_we | mem_we;
    end
    if (rom_req) seen_rom++;
    if (pc_load | pc_inc) begin
      n_strobes++;
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: pc_load=%0b pc_inc=%0b with no instruction pending",
                 pc_load, pc_inc);
      end else begin
        e = q.pop_front();
        check("pc_load", 32'(pc_load), 32'(e.pl));
        check("pc_inc", 32'(pc_inc), 32'(e.pi));
        check("instr_cycles", 32'(obs_cyc), 32'(e.cyc));
        check("mem_req_cycles", 32'(obs_mc), 32'(e.mc));
        check("mem_we", 32'(obs_we), 32'(e.we));
        check("exec_en_cycle", 32'(obs_exec), 32'd2);
      end
      clear_obs();
    end
    if (rom_req) begin
      zr       = cur.zr;
      ng       = cur.ng;
      pc_value = 16'h0010;
      a_value  = cur.aeq ? 16'h0010 : 16'h0123;
    end
    rom_ack  = rom_req & ack_rom;
    rom_data = cur.instr;
    mem_ack  = mem_req & (obs_mc == cur.mwait + 1);
  endtask

  task automatic wait_strobe(input int unsigned limit);
    int unsigned tgt;
    tgt = n_strobes + 1;
    for (int unsigned i = 0; i < limit && n_strobes < tgt; i++) step();
    if (n_strobes < tgt) begin
      n_checks++;
      n_errors++;
      $display("FAIL strobe_timeout: no pc strobe within %0d cycles, expected one", limit);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    run_en  = 1'b0;
    ack_rom = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_obs();
    q.delete();
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({rom_req, mem_req, mem_we, exec_en, pc_load, pc_inc, halted, bus_err, instr});
  endfunction

  initial begin
    // {instr, zr, ng, a==pc, mem wait, pc_load, pc_inc, cycles, mem_req cycles, mem_we}
    tbl[0]  = '{16'h0005, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 3, 0, 1'b0};
    tbl[1]  = '{16'hE301, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 3, 0, 1'b0};
    tbl[2]  = '{16'hE301, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 3, 0, 1'b0};
    tbl[3]  = '{16'hE308, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1, 7, 4, 1'b1};
    tbl[4]  = '{16'hFC10, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 4, 1, 1'b0};
    tbl[5]  = '{16'hE302, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 3, 0, 1'b0};
    tbl[6]  = '{16'hE304, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 3, 0, 1'b0};
    tbl[7]  = '{16'hE304, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 3, 0, 1'b0};
    tbl[8]  = '{16'hE305, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 3, 0, 1'b0};
    tbl[9]  = '{16'h7FFF, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 3, 0, 1'b0};
    tbl[10] = '{16'hEA87, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 3, 0, 1'b0};
    tbl[11] = '{16'hE30A, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 5, 2, 1'b1};
    tbl[12] = '{16'hE301, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 3, 0, 1'b0};
    tbl[13] = '{16'h0005, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 3, 0, 1'b0};
    cur = tbl[0];
    n_strobes = 0;
    seen_rom  = 0;
    clear_obs();

    do_reset();
    check("reset_outputs", all_outs(), 32'd0);

    run_en = 1'b1;
    foreach (tbl[i]) begin
      cur = tbl[i];
      push_exp(tbl[i]);
      wait_strobe(30);
    end
    check("table_no_bus_err", 32'(bus_err), 32'd0);
    check("table_not_halted", 32'(halted), 32'd0);

    // Taken jump to its own address halts; only reset leaves HALT.
    do_reset();
    cur = '{16'hEA87, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 3, 0, 1'b0};
    push_exp(cur);
    run_en = 1'b1;
    wait_strobe(20);
    step();
    check("halt_set", 32'(halted), 32'd1);
    seen_rom = 0;
    repeat (5) step();
    check("halt_no_fetch", 32'(seen_rom), 32'd0);
    check("halt_quiet", 32'({pc_load, pc_inc, mem_req, exec_en, halted}), 32'd1);
    do_reset();
    check("halt_reset_clears", all_outs(), 32'd0);
    seen_rom = 0;
    repeat (3) step();
    check("idle_after_reset", 32'(seen_rom), 32'd0);

    // ROM never acknowledges.
    do_reset();
    ack_rom = 1'b0;
    run_en  = 1'b1;
    seen_rom = 0;
    for (int i = 0; i < 20 && !halted; i++) step();
    check("rom_timeout_req_cycles", 32'(seen_rom), 32'd4);
    check("rom_timeout_bus_err", 32'(bus_err), 32'd1);
    check("rom_timeout_halted", 32'(halted), 32'd1);
    check("rom_timeout_strobes", 32'({pc_load, pc_inc, rom_req}), 32'd0);

    // Data memory never acknowledges.
    do_reset();
    cur    = '{16'hE308, 1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b1, 0, 0, 1'b0};
    run_en = 1'b1;
    for (int i = 0; i < 20 && !halted; i++) step();
    check("mem_timeout_req_cycles", 32'(obs_mc), 32'd4);
    check("mem_timeout_bus_err", 32'(bus_err), 32'd1);
    check("mem_timeout_halted", 32'(halted), 32'd1);
    do_reset();
    check("bus_err_reset_clears", 32'(bus_err), 32'd0);

    // Reset in the middle of a data access.
    cur    = '{16'hE308, 1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b1, 0, 0, 1'b0};
    run_en = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = mem_req;
    end
    check("mid_mem_reached", 32'(found), 32'd1);
    reset  = 1'b1;
    run_en = 1'b0;
    step();
    check("reset_mid_mem", all_outs(), 32'd0);
    reset = 1'b0;
    clear_obs();
    seen_rom = 0;
    repeat (4) step();
    check("reset_mid_mem_idle", 32'(seen_rom), 32'd0);

    // run_en dropped during EXEC: instruction finishes, then idle.
    do_reset();
    cur = '{16'hE308, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b1, 6, 3, 1'b1};
    push_exp(cur);
    run_en = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = exec_en;
    end
    run_en = 1'b0;
    wait_strobe(20);
    seen_rom = 0;
    repeat (5) step();
    check("run_en_stop_no_fetch", 32'(seen_rom), 32'd0);
    check("run_en_stop_not_halted", 32'(halted), 32'd0);

    // Stray rom_ack while idle must not load an instruction.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      found    = found | exec_en;
      rom_ack  = 1'b1;
      rom_data = 16'hFFFF;
    end
    @(negedge clk);
    rom_ack = 1'b0;
    check("stray_ack_instr", 32'(instr), 32'd0);
    check("stray_ack_no_exec", 32'(found | exec_en), 32'd0);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
